// File: rtl/apb_completer_if.sv
// APB completer-side bus bundle: request signals from the bridge, registered response back.
interface apb_completer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_completer.sv
// APB completer: byte-strobed register file with protection check, programmable wait states,
// PSLVERR on decode errors and on transfers abandoned by psel dropping early.
module apb_completer #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned PROT_LSB    = 8
) (
  input logic            pclk,
  input logic            presetn,
  apb_completer_if.slave apb
);

  localparam int unsigned IdxW  = $clog2(NUM_REGS);
  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned DecW  = PROT_LSB + 3;

  typedef enum logic [1:0] {StIdle, StAccess, StResp, StAbort} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [DecW-1:0]       addr_q;
  logic                  write_q;
  logic [2:0]            prot_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [StrbW-1:0]      strb_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  lat_err;
  logic                  in_err;
  logic [DATA_WIDTH-1:0] lat_rdata;
  logic [DATA_WIDTH-1:0] in_rdata;
  logic                  commit;

  // Address bits above the region attributes never reach the decoder.
  function automatic logic addr_err(input logic [DecW-1:0] a, input logic [2:0] prot);
    logic e;
    e = (a[1:0] != 2'b00);
    for (int unsigned i = IdxW + 2; i < PROT_LSB; i++) begin
      e = e | a[i];
    end
    e = e | ((a[PROT_LSB+2 -: 3] & ~prot) != 3'b000);
    return e;
  endfunction

  always_comb begin
    lat_err   = addr_err(addr_q, prot_q);
    in_err    = addr_err(apb.paddr[DecW-1:0], apb.pprot);
    lat_rdata = (write_q || lat_err) ? '0 : regs_q[addr_q[IdxW+1:2]];
    in_rdata  = (apb.pwrite || in_err) ? '0 : regs_q[apb.paddr[IdxW+1:2]];
    commit    = (state_q == StResp) && apb.psel && apb.penable && write_q && !lat_err;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      prot_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A bare penable without a setup phase is ignored.
          if (apb.psel && !apb.penable) begin
            addr_q  <= apb.paddr[DecW-1:0];
            write_q <= apb.pwrite;
            prot_q  <= apb.pprot;
            wdata_q <= apb.pwdata;
            strb_q  <= apb.pstrb;
            cnt_q   <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              pready_q  <= 1'b1;
              pslverr_q <= in_err;
              prdata_q  <= in_rdata;
              state_q   <= StResp;
            end else begin
              state_q <= StAccess;
            end
          end
        end
        StAccess: begin
          if (!apb.psel) begin
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            prdata_q  <= '0;
            state_q   <= StAbort;
          end else if (cnt_q <= 4'd1) begin
            cnt_q     <= '0;
            pready_q  <= 1'b1;
            pslverr_q <= lat_err;
            prdata_q  <= lat_rdata;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (!apb.psel) begin
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            prdata_q  <= '0;
            state_q   <= StAbort;
          end else if (apb.penable) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            state_q   <= StIdle;
          end
        end
        StAbort: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      for (int unsigned b = 0; b < StrbW; b++) begin
        if (strb_q[b]) begin
          regs_q[addr_q[IdxW+1:2]][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;

endmodule

// File: doc/apb_completer.md
Name: apb_completer

Overview:
- APB completer directly downstream of the APB bridge; the bridge issues transfers, this block services them.
- Contains a NUM_REGS x DATA_WIDTH register file with byte strobes, a protection unit driven by PPROT, programmable wait states and PSLVERR generation.
- Connects through the apb_if completer signals.

Parameters:
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width.
- NUM_REGS, 16, number of words in the register file. Must be a power of 2, at least 2.
- WAIT_STATES, 1, access-phase cycles with PREADY low before completion (0..15).
- PROT_LSB, 8, lowest of three paddr bits that encode region attributes.

Ports:
- pclk  in  1  APB clock.
- presetn  in  1  Reset. Asynchronous assert, active low.
- psel  in  1  Select.
- penable  in  1  Access-phase enable.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  Byte address.
- pprot  in  3  Protection: [0] privileged, [1] non-secure, [2] instruction.
- pwdata  in  DATA_WIDTH  Write data.
- pstrb  in  DATA_WIDTH/8  Write byte strobes.
- pready  out  1  Transfer complete. Registered.
- prdata  out  DATA_WIDTH  Read data. Registered.
- pslverr  out  1  Error response. Registered; valid only while pready=1.

Behaviour:
- Reset: the clock is pclk. Reset is presetn, asynchronous and active-low. During reset pready=0, pslverr=0, prdata=0, all registers=0, FSM=IDLE. If reset asserts mid-transfer, the transfer is dropped with no response and no register update.
- FSM states:
  - IDLE: on a sampled psel=1 and penable=0 (setup), latch paddr, pwrite, pprot, pwdata and pstrb, load wait counter = WAIT_STATES, go to ACCESS. If penable=1 is sampled without a prior setup, ignore it and stay in IDLE.
  - ACCESS: while the counter > 0 and psel=1, decrement. When the counter reaches 0, set pready=1 (with pslverr and prdata) and go to RESP. With WAIT_STATES=0, pready is set at the setup-sampling edge, giving zero wait cycles.
  - RESP: pready is high. The transfer completes at the edge where psel=1, penable=1 and pready=1 are sampled. At that edge clear pready and pslverr, go to IDLE, and commit any write. A back-to-back setup is legal in the cycle after completion.
  - ABORT: entered from ACCESS or RESP when psel=0 is sampled before completion. Drive pready=1 and pslverr=1 for exactly one cycle, prdata=0, no write, then return to IDLE.
- Error decode uses the latched values:
  - misaligned: paddr[1:0] != 0
  - out of range: any of paddr[PROT_LSB-1 : log2(NUM_REGS)+2] nonzero
  - protection: (paddr[PROT_LSB+2:PROT_LSB] & ~pprot) != 0, i.e. every region attribute bit set in the address requires the matching pprot bit to be 1
  - paddr bits above PROT_LSB+2 are ignored.
- On any error: pslverr=1 at completion, prdata=0, no write. Error responses use the same latency as successful ones.
- Register index is paddr[log2(NUM_REGS)+1:2].
- Reads: prdata = reg[index], captured when pready is set. prdata=0 for writes and errors, and returns to 0 after completion.
- Writes: commit at the completion edge, byte lane i written only if pstrb[i]=1. pstrb=0 is a legal no-op with no error.
- Changes on paddr/pwrite/pprot/pwdata during ACCESS are ignored; the latched values are used.

Test Plan:
- Reset, WAIT_STATES=1: read paddr=0x4, pprot=000 -> 1 wait cycle, pready with pslverr=0, prdata=0x00000000.
- Write 0x4 data 0xDEADBEEF pstrb=0xF, then write pstrb=0x2 data 0x0000AA00, then read -> prdata=0xDEADAAEF, no errors.
- paddr=0x704 (attributes 111): pprot=111 -> ok. pprot=110, 101 and 011 -> each pslverr=1, register unchanged.
- paddr=0x3, or paddr=0x44 with NUM_REGS=16 -> pslverr=1, prdata=0.
- psel dropped in the first access cycle -> next cycle pready=1 and pslverr=1 for one cycle, then IDLE. A follow-up read succeeds.
- Reset pulsed during the wait phase of a write to 0x8 -> outputs go to 0 immediately, and reg[2] reads back 0.
